// File: rtl/afe4400_spi_master.sv
// afe4400_spi_master: SPI mode-0 master running 32-bit AFE4400 register frames (addr then data, MSB first).
// Define AFE_READ_SEQ_EN to wrap each read in CONTROL0 SPI_READ set/clear write frames.
module afe4400_spi_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 24,
    parameter int CS_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = ($clog2(FRAME_W) > 4) ? $clog2(FRAME_W) : 4;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;   // 0 = SCLK high half, 1 = SCLK low half
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               rd_q, rd_d;
    logic               smp_q, smp_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               busy_d, done_d, cs_n_d, sclk_d, mosi_d;

`ifdef AFE_READ_SEQ_EN
    localparam logic [FRAME_W-1:0] SPI_READ_SET = FRAME_W'(1);
    logic [1:0]         frm_q, frm_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        smp_d   = smp_q;
        rdata_d = rdata;
`ifdef AFE_READ_SEQ_EN
        frm_d   = frm_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_d    = rd;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETUP;
`ifdef AFE_READ_SEQ_EN
                    addr_d  = addr;
                    wdata_d = wdata;
                    frm_d   = 2'd0;
                    smp_d   = 1'b0;
                    tx_d    = rd ? SPI_READ_SET : {addr, wdata};
`else
                    smp_d   = rd;
                    tx_d    = {addr, wdata};
`endif
                end
            end
            S_SETUP: begin
                phase_d = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    // SCLK falls here: capture MISO and present the next MOSI bit
                    phase_d = 1'b1;
                    tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
                    if (smp_q) begin
                        rx_d = {rx_q[DATA_W-2:0], spi_miso};
                    end
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == LAST_HOLD) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
`ifdef AFE_READ_SEQ_EN
                    if (rd_q && frm_q != 2'd2) begin
                        state_d = S_GAP;
                    end
`endif
                    if (state_d == S_DONE && rd_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
`ifdef AFE_READ_SEQ_EN
                frm_d   = frm_q + 2'd1;
                phase_d = 1'b0;
                state_d = S_SETUP;
                if (frm_q == 2'd0) begin
                    tx_d  = {addr_q, wdata_q};
                    smp_d = 1'b1;
                end else begin
                    tx_d  = '0;
                    smp_d = 1'b0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = state_d inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP};
        done_d = (state_d == S_DONE);
        cs_n_d = !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
        sclk_d = (state_d == S_SHIFT) && !phase_d;
        mosi_d = (state_d inside {S_SETUP, S_SHIFT}) && tx_d[FRAME_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rd_q     <= 1'b0;
            smp_q    <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
`ifdef AFE_READ_SEQ_EN
            frm_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rd_q     <= rd_d;
            smp_q    <= smp_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            done     <= done_d;
            spi_cs_n <= cs_n_d;
            spi_sclk <= sclk_d;
            spi_mosi <= mosi_d;
`ifdef AFE_READ_SEQ_EN
            frm_q    <= frm_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`endif
        end
    end

endmodule

// File: tb/tb_afe4400_spi_master.sv
// tb_afe4400_spi_master: directed vector bench for afe4400_spi_master (default and CS_HOLD=5 instances).
module tb_afe4400_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, rd, spi_miso, sel;
    logic [7:0]  addr;
    logic [23:0] wdata;

    logic        busy0, done0, cs0, sclk0, mosi0;
    logic [23:0] rdata0;
    logic        busy5, done5, cs5, sclk5, mosi5;
    logic [23:0] rdata5;
    logic        busy, done, cs_n, sclk, mosi;
    logic [23:0] rdata;

    always_comb begin
        busy  = sel ? busy5  : busy0;
        done  = sel ? done5  : done0;
        cs_n  = sel ? cs5    : cs0;
        sclk  = sel ? sclk5  : sclk0;
        mosi  = sel ? mosi5  : mosi0;
        rdata = sel ? rdata5 : rdata0;
    end

    afe4400_spi_master dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .rd(rd), .addr(addr), .wdata(wdata),
        .busy(busy0), .done(done0), .rdata(rdata0),
        .spi_cs_n(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(spi_miso)
    );

    afe4400_spi_master #(.CS_HOLD(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .rd(rd), .addr(addr), .wdata(wdata),
        .busy(busy5), .done(done5), .rdata(rdata5),
        .spi_cs_n(cs5), .spi_sclk(sclk5), .spi_mosi(mosi5), .spi_miso(spi_miso)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    logic [31:0] words [4];
    int          n_win, pulses, dones, done_c, done_c2, min_gap, hold_meas, bits;
    logic [23:0] rd_at_done;
    logic        busy_at_done, busy1;

    // One request observed cycle by cycle from the host side; the slave drives MISO during SCLK low.
    task automatic run_req(input logic r, input logic [7:0] a, input logic [23:0] d,
                           input logic [31:0] mw, input int hold_cyc,
                           input logic [7:0] a2, input logic [23:0] d2, input int total);
        logic [31:0] word;
        logic        in_win, prev_sclk;
        int          last_fall, last_rise;
        n_win = 0; pulses = 0; dones = 0; done_c = -1; done_c2 = -1;
        min_gap = 1000; hold_meas = -1; bits = 0;
        rd_at_done = '0; busy_at_done = 1'b0; busy1 = 1'b0;
        word = '0; in_win = 1'b0; prev_sclk = 1'b0; last_fall = 0; last_rise = 0;
        rd = r; addr = a; wdata = d; start = 1'b1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy1 = busy;
                addr  = a2;
                wdata = d2;
            end
            if (c == hold_cyc) start = 1'b0;
            if (!cs_n) begin
                if (!in_win) begin
                    in_win = 1'b1;
                    word = '0;
                    bits = 0;
                    if (n_win > 0 && (c - last_rise) < min_gap) min_gap = c - last_rise;
                end
                if (sclk && !prev_sclk) begin
                    word = {word[30:0], mosi};
                    bits++;
                    pulses++;
                end
                if (!sclk && prev_sclk) last_fall = c;
            end else if (in_win) begin
                in_win = 1'b0;
                if (n_win < 4) words[n_win] = word;
                n_win++;
                last_rise = c;
                hold_meas = c - last_fall - 1;
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_c = c;
                    rd_at_done = rdata;
                    busy_at_done = busy;
                end else if (dones == 2) begin
                    done_c2 = c;
                end
            end
            prev_sclk = sclk;
            if (!cs_n && !sclk && bits < 32) spi_miso = mw[31-bits];
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  a;
        logic [23:0] d;
        logic [31:0] mw;
        logic [31:0] exp_mosi;
        logic [23:0] exp_rdata;
    } vec_t;

    vec_t vt [6];

    initial begin
        int   nw, expd, rbits;
        logic ps, hit;

        vt[0] = '{1'b0, 8'h21, 24'h00ABCD, 32'hFFFFFFFF, 32'h2100ABCD, 24'h000000};
        vt[1] = '{1'b1, 8'h2A, 24'h000000, 32'hA5123456, 32'h2A000000, 24'h123456};
        vt[2] = '{1'b0, 8'hFF, 24'hFFFFFF, 32'h00000000, 32'hFFFFFFFF, 24'h123456};
        vt[3] = '{1'b1, 8'h01, 24'h000000, 32'h00FEDCBA, 32'h01000000, 24'hFEDCBA};
        vt[4] = '{1'b1, 8'h2C, 24'h000000, 32'hFF000001, 32'h2C000000, 24'h000001};
        vt[5] = '{1'b0, 8'h00, 24'h000001, 32'hAAAAAAAA, 32'h00000001, 24'h000001};

        rst_n = 1'b0; start = 1'b0; rd = 1'b0; addr = '0; wdata = '0; spi_miso = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted asynchronously in the middle of a read frame
        rd = 1'b1; addr = 8'h2A; wdata = '0; start = 1'b1; spi_miso = 1'b1;
        rbits = 0; ps = 1'b0; hit = 1'b0;
        for (int c = 1; c <= 40 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sclk && !ps) rbits++;
            ps = sclk;
            if (rbits == 10) hit = 1'b1;
        end
        chk("midrst_reach_bit10", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spi_miso = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
`ifdef AFE_READ_SEQ_EN
            nw   = vt[i].r ? 3 : 1;
            expd = vt[i].r ? 204 : 68;
`else
            nw   = 1;
            expd = 68;
`endif
            run_req(vt[i].r, vt[i].a, vt[i].d, vt[i].mw, 1, vt[i].a, vt[i].d, expd + 4);
            chk($sformatf("v%0d_windows", i), 32'(n_win), 32'(nw));
            if (nw == 3) begin
                chk($sformatf("v%0d_frame1", i), words[0], 32'h00000001);
                chk($sformatf("v%0d_frame2", i), words[1], vt[i].exp_mosi);
                chk($sformatf("v%0d_frame3", i), words[2], 32'h00000000);
                chk($sformatf("v%0d_gap", i), 32'(min_gap), 32'd1);
            end else begin
                chk($sformatf("v%0d_mosi", i), words[0], vt[i].exp_mosi);
            end
            chk($sformatf("v%0d_sclk_pulses", i), 32'(pulses), 32'(32 * nw));
            chk($sformatf("v%0d_done_count", i), 32'(dones), 32'd1);
            chk($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(expd));
            chk($sformatf("v%0d_rdata", i), 32'(rd_at_done), 32'(vt[i].exp_rdata));
            chk($sformatf("v%0d_busy_start", i), 32'(busy1), 32'd1);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy_at_done), 32'd0);
            chk($sformatf("v%0d_cs_hold", i), 32'(hold_meas), 32'd2);
        end

        // start held high across two frames, operands changed while busy
        run_req(1'b0, 8'h10, 24'h111111, 32'h0, 100, 8'h11, 24'h222222, 160);
        chk("btb_windows", 32'(n_win), 32'd2);
        chk("btb_frame1", words[0], 32'h10111111);
        chk("btb_frame2", words[1], 32'h11222222);
        chk("btb_done_count", 32'(dones), 32'd2);
        chk("btb_done1_cycle", 32'(done_c), 32'd68);
        chk("btb_done2_cycle", 32'(done_c2), 32'd137);
        chk("btb_cs_gap", 32'(min_gap), 32'd2);

        sel = 1'b1;
        @(negedge clk);
        run_req(1'b0, 8'h21, 24'h00ABCD, 32'h0, 1, 8'h21, 24'h00ABCD, 76);
        chk("hold5_mosi", words[0], 32'h2100ABCD);
        chk("hold5_done_count", 32'(dones), 32'd1);
        chk("hold5_done_cycle", 32'(done_c), 32'd71);
        chk("hold5_cs_hold", 32'(hold_meas), 32'd5);
        chk("hold5_sclk_pulses", 32'(pulses), 32'd32);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
